// File: rtl/mem_stage_pkg.sv
// Shared types and sizes for the LEGv8 memory-stage controller.
package mem_stage_pkg;

  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned MIN_CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach n, never narrower than MIN_CNT_W.
  function automatic int unsigned timeout_cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < MIN_CNT_W) ? MIN_CNT_W : w;
  endfunction

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; a bubble clears the write-back controls and holds the data fields.
module mem_wb_register
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  bubble,
  input  logic                  regwrite_in,
  input  logic                  memtoreg_in,
  input  logic [DATA_W-1:0]     readdata_in,
  input  logic [DATA_W-1:0]     aluresult_in,
  input  logic [REG_ADDR_W-1:0] wr_in,
  output logic                  regwrite_out,
  output logic                  memtoreg_out,
  output logic [DATA_W-1:0]     readdata_out,
  output logic [DATA_W-1:0]     aluresult_out,
  output logic [REG_ADDR_W-1:0] wr_out
);

  // Load the stage payload, or insert a bubble while the pipeline is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_out  <= 1'b0;
      memtoreg_out  <= 1'b0;
      readdata_out  <= '0;
      aluresult_out <= '0;
      wr_out        <= '0;
    end else if (bubble) begin
      regwrite_out  <= 1'b0;
      memtoreg_out  <= 1'b0;
    end else begin
      regwrite_out  <= regwrite_in;
      memtoreg_out  <= memtoreg_in;
      readdata_out  <= readdata_in;
      aluresult_out <= aluresult_in;
      wr_out        <= wr_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: branch resolve, data-memory req/ack handshake, pipeline stall,
// and MEM/WB register. Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  RegWrite_s4,
  input  logic                  MemtoReg_s4,
  input  logic                  Branch_s4,
  input  logic                  MemRead_s4,
  input  logic                  MemWrite_s4,
  input  logic [DATA_W-1:0]     BranchAdder_s4,
  input  logic                  Zero_s4,
  input  logic [DATA_W-1:0]     ALUResult_s4,
  input  logic [DATA_W-1:0]     RD2_s4,
  input  logic [REG_ADDR_W-1:0] WR_s4,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall,
  output logic                  PCSrc,
  output logic [DATA_W-1:0]     BranchTarget,
  output logic                  RegWrite_s5,
  output logic                  MemtoReg_s5,
  output logic [DATA_W-1:0]     ReadData_s5,
  output logic [DATA_W-1:0]     ALUResult_s5,
  output logic [REG_ADDR_W-1:0] WR_s5,
  output logic                  mem_err
);

  state_t            state;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_op_c;
  logic              abort_c;
  logic              regwrite_c;
  logic [DATA_W-1:0] readdata_c;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
`endif

  // Stall and branch redirect are combinational so upstream sees them in the same cycle.
  assign mem_op_c     = MemRead_s4 | MemWrite_s4;
  assign stall        = reset_n & (((state == IDLE) & mem_op_c) | (state == WAIT));
  assign PCSrc        = Branch_s4 & Zero_s4 & (state == IDLE);
  assign BranchTarget = BranchAdder_s4;

`ifdef MEM_TIMEOUT_EN
  assign abort_c = timed_out & (state == DONE);
`else
  assign abort_c = 1'b0;
  assign mem_err = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Write-back payload: read data only from a completed access, no register write after an abort.
  assign regwrite_c = RegWrite_s4 & ~abort_c;
  assign readdata_c = (state == DONE) ? rdata_q : '0;

  // Access sequencer with the memory request latches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      mem_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op_c) begin
            mem_addr  <= ALUResult_s4;
            mem_wdata <= RD2_s4;
            mem_we    <= MemWrite_s4;
            mem_req   <= 1'b1;
            rdata_q   <= '0;
            state     <= WAIT;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            timed_out <= 1'b0;
`endif
          end
        end
        WAIT: begin
          if (mem_ack) begin
            if (!mem_we) rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req   <= 1'b0;
            mem_err   <= 1'b1;
            timed_out <= 1'b1;
            rdata_q   <= '0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_wb_register #(
    .DATA_W (DATA_W)
  ) u_mem_wb (
    .clock         (clock),
    .reset_n       (reset_n),
    .bubble        (stall),
    .regwrite_in   (regwrite_c),
    .memtoreg_in   (MemtoReg_s4),
    .readdata_in   (readdata_c),
    .aluresult_in  (ALUResult_s4),
    .wr_in         (WR_s4),
    .regwrite_out  (RegWrite_s5),
    .memtoreg_out  (MemtoReg_s5),
    .readdata_out  (ReadData_s5),
    .aluresult_out (ALUResult_s5),
    .wr_out        (WR_s5)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: instruction-level schedule model plus literal checks.
module tb_mem_stage_ctrl;

  localparam int TO = 8;

  typedef struct {
    logic        rw, m2r, br, mr, mw, z;
    logic [63:0] badd, alu, rd2;
    logic [4:0]  wr;
  } instr_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        RegWrite_s4, MemtoReg_s4, Branch_s4, MemRead_s4, MemWrite_s4, Zero_s4;
  logic [63:0] BranchAdder_s4, ALUResult_s4, RD2_s4;
  logic [4:0]  WR_s4;
  logic        mem_req, mem_we, mem_ack, stall, PCSrc, RegWrite_s5, MemtoReg_s5, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, BranchTarget, ReadData_s5, ALUResult_s5;
  logic [4:0]  WR_s5;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  bit chk_en = 1'b0;
  bit stray_ack = 1'b0;

  // model expectations for the current cycle
  logic        exp_stall, exp_req, exp_we, exp_pcsrc, exp_rw5, exp_m2r5, exp_err;
  logic [63:0] exp_addr, exp_wdata, exp_target, exp_rd5, exp_alu5;
  logic [4:0]  exp_wr5;

  // values sampled by the driver for literal checks
  logic        pcsrc_seen, wait_we;
  logic [63:0] target_seen, wait_addr, wait_wdata;

  always #5 clock = ~clock;

  mem_stage_ctrl #(.DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .RegWrite_s4(RegWrite_s4), .MemtoReg_s4(MemtoReg_s4), .Branch_s4(Branch_s4),
    .MemRead_s4(MemRead_s4), .MemWrite_s4(MemWrite_s4), .BranchAdder_s4(BranchAdder_s4),
    .Zero_s4(Zero_s4), .ALUResult_s4(ALUResult_s4), .RD2_s4(RD2_s4), .WR_s4(WR_s4),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .RegWrite_s5(RegWrite_s5), .MemtoReg_s5(MemtoReg_s5),
    .ReadData_s5(ReadData_s5), .ALUResult_s5(ALUResult_s5), .WR_s5(WR_s5), .mem_err(mem_err)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic m2r, input logic br,
                                input logic mr, input logic mw, input logic z,
                                input logic [63:0] badd, input logic [63:0] alu,
                                input logic [63:0] rd2, input logic [4:0] wr);
    instr_t i;
    i.rw = rw; i.m2r = m2r; i.br = br; i.mr = mr; i.mw = mw; i.z = z;
    i.badd = badd; i.alu = alu; i.rd2 = rd2; i.wr = wr;
    return i;
  endfunction

  task automatic drive(input instr_t in);
    RegWrite_s4 = in.rw; MemtoReg_s4 = in.m2r; Branch_s4 = in.br;
    MemRead_s4 = in.mr; MemWrite_s4 = in.mw; Zero_s4 = in.z;
    BranchAdder_s4 = in.badd; ALUResult_s4 = in.alu; RD2_s4 = in.rd2; WR_s4 = in.wr;
  endtask

  // The instruction has left the stage: its write-back fields become visible.
  task automatic retire(input instr_t in, input logic [63:0] rd, input logic wb_ok);
    exp_rw5 = in.rw & wb_ok; exp_m2r5 = in.m2r; exp_rd5 = rd;
    exp_alu5 = in.alu; exp_wr5 = in.wr;
  endtask

  // Present one instruction in EX/MEM and hold it until it retires.
  // lat = WAIT cycles until ack; noack = never acknowledge (timeout build only).
  task automatic do_instr(input instr_t in, input int lat, input logic [63:0] rdata, input bit noack);
    bit is_mem;
    int nwait;
    is_mem = in.mr | in.mw;
    nwait  = noack ? TO : lat;
    drive(in);
    mem_ack = stray_ack; mem_rdata = 64'hFFFF_0000;
    exp_target = in.badd; exp_pcsrc = in.br & in.z; exp_stall = is_mem; exp_req = 1'b0;
    #1;
    pcsrc_seen = PCSrc; target_seen = BranchTarget;
    @(posedge clock); #1;
    if (!is_mem) begin
      retire(in, 64'd0, 1'b1);
      return;
    end
    exp_rw5 = 1'b0; exp_m2r5 = 1'b0;
    exp_we = in.mw; exp_addr = in.alu; exp_wdata = in.rd2;
    for (int w = 1; w <= nwait; w++) begin
      exp_stall = 1'b1; exp_req = 1'b1; exp_pcsrc = 1'b0;
      mem_ack   = !noack && (w == nwait);
      mem_rdata = mem_ack ? rdata : (64'hBAD0_0000 + 64'(w));
      #1;
      wait_we = mem_we; wait_addr = mem_addr; wait_wdata = mem_wdata;
      @(posedge clock); #1;
      exp_rw5 = 1'b0; exp_m2r5 = 1'b0;
    end
    if (noack) exp_err = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_pcsrc = 1'b0;
    mem_ack = stray_ack; mem_rdata = 64'hFFFF_0001;
    @(posedge clock); #1;
    retire(in, (in.mw || noack) ? 64'd0 : rdata, !noack);
  endtask

  task automatic model_reset();
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_pcsrc = 1'b0;
    exp_rw5 = 1'b0; exp_m2r5 = 1'b0; exp_err = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_target = '0; exp_rd5 = '0; exp_alu5 = '0; exp_wr5 = '0;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk1("stall", stall, exp_stall);
      chk1("mem_req", mem_req, exp_req);
      chk1("PCSrc", PCSrc, exp_pcsrc);
      chk64("BranchTarget", BranchTarget, exp_target);
      chk1("RegWrite_s5", RegWrite_s5, exp_rw5);
      chk1("MemtoReg_s5", MemtoReg_s5, exp_m2r5);
      chk64("ReadData_s5", ReadData_s5, exp_rd5);
      chk64("ALUResult_s5", ALUResult_s5, exp_alu5);
      chk64("WR_s5", 64'(WR_s5), 64'(exp_wr5));
      chk1("mem_err", mem_err, exp_err);
      if (exp_req) begin
        chk1("mem_we", mem_we, exp_we);
        chk64("mem_addr", mem_addr, exp_addr);
        chk64("mem_wdata", mem_wdata, exp_wdata);
      end
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t nop, ldur;
    int s0, r0;
    nop  = mk(0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 5'd0);
    ldur = mk(1, 1, 0, 1, 0, 0, 64'd0, 64'h100, 64'd0, 5'd5);
    reset_n = 1'b0;
    drive(nop);
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk64("rst_mem_addr", mem_addr, 64'd0);
    chk64("rst_mem_wdata", mem_wdata, 64'd0);
    chk1("rst_RegWrite_s5", RegWrite_s5, 1'b0);
    chk64("rst_ALUResult_s5", ALUResult_s5, 64'd0);
    chk1("rst_mem_err", mem_err, 1'b0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // ALU instruction, no stall
    s0 = stall_cnt;
    do_instr(mk(1, 0, 0, 0, 0, 0, 64'd0, 64'h2A, 64'd0, 5'd3), 0, 64'd0, 1'b0);
    chk1("alu_RegWrite_s5", RegWrite_s5, 1'b1);
    chk64("alu_ALUResult_s5", ALUResult_s5, 64'h2A);
    chk64("alu_WR_s5", 64'(WR_s5), 64'd3);
    chk64("alu_stall_cycles", 64'(stall_cnt - s0), 64'd0);

    // LDUR 0x100, ack in 4th WAIT cycle
    s0 = stall_cnt; r0 = req_cnt;
    do_instr(ldur, 4, 64'hDEAD, 1'b0);
    chk64("ld_stall_cycles", 64'(stall_cnt - s0), 64'd5);
    chk64("ld_req_cycles", 64'(req_cnt - r0), 64'd4);
    chk64("ld_ReadData_s5", ReadData_s5, 64'hDEAD);
    chk1("ld_MemtoReg_s5", MemtoReg_s5, 1'b1);
    chk1("ld_RegWrite_s5", RegWrite_s5, 1'b1);

    // STUR 0x55 to 0x8, immediate ack
    s0 = stall_cnt;
    do_instr(mk(0, 0, 0, 0, 1, 0, 64'd0, 64'h8, 64'h55, 5'd0), 1, 64'h1234, 1'b0);
    chk1("st_mem_we", wait_we, 1'b1);
    chk64("st_mem_wdata", wait_wdata, 64'h55);
    chk64("st_mem_addr", wait_addr, 64'h8);
    chk64("st_stall_cycles", 64'(stall_cnt - s0), 64'd2);
    chk1("st_RegWrite_s5", RegWrite_s5, 1'b0);

    // CBZ taken and not taken
    do_instr(mk(0, 0, 1, 0, 0, 1, 64'h40, 64'd0, 64'd0, 5'd0), 0, 64'd0, 1'b0);
    chk1("cbz_taken_PCSrc", pcsrc_seen, 1'b1);
    chk64("cbz_BranchTarget", target_seen, 64'h40);
    do_instr(mk(0, 0, 1, 0, 0, 0, 64'h40, 64'd1, 64'd0, 5'd0), 0, 64'd0, 1'b0);
    chk1("cbz_not_taken_PCSrc", pcsrc_seen, 1'b0);

    // read and write together: write wins; stray acks outside WAIT ignored
    stray_ack = 1'b1;
    do_instr(mk(1, 1, 0, 1, 1, 0, 64'd0, 64'h200, 64'h77, 5'd7), 2, 64'hCAFE, 1'b0);
    chk1("rw_mem_we", wait_we, 1'b1);
    chk64("rw_ReadData_s5", ReadData_s5, 64'd0);
    do_instr(mk(1, 0, 0, 0, 0, 0, 64'd0, 64'h99, 64'd0, 5'd9), 0, 64'd0, 1'b0);
    stray_ack = 1'b0;
    do_instr(mk(1, 1, 0, 1, 0, 0, 64'd0, 64'h3, 64'd0, 5'd31), 1, 64'h0123_4567_89AB_CDEF, 1'b0);
    chk64("ld2_ReadData_s5", ReadData_s5, 64'h0123_4567_89AB_CDEF);

    // asynchronous reset during WAIT
    chk_en = 1'b0;
    drive(ldur);
    mem_ack = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk1("pre_rst_mem_req", mem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk1("async_rst_stall", stall, 1'b0);
    drive(nop);
    #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    model_reset();
    chk_en = 1'b1;
    do_instr(ldur, 2, 64'hBEEF, 1'b0);
    chk64("post_rst_ReadData_s5", ReadData_s5, 64'hBEEF);
    chk1("post_rst_RegWrite_s5", RegWrite_s5, 1'b1);

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after TO WAIT cycles
    r0 = req_cnt;
    do_instr(ldur, 0, 64'd0, 1'b1);
    chk64("to_req_cycles", 64'(req_cnt - r0), 64'd8);
    chk1("to_mem_err", mem_err, 1'b1);
    chk1("to_RegWrite_s5", RegWrite_s5, 1'b0);
    do_instr(mk(1, 0, 0, 0, 0, 0, 64'd0, 64'h5, 64'd0, 5'd4), 0, 64'd0, 1'b0);
    chk1("to_err_sticky", mem_err, 1'b1);
    chk1("to_resume_RegWrite_s5", RegWrite_s5, 1'b1);
`endif

    do_instr(nop, 0, 64'd0, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the pipelined LEGv8 core, the consuming end of the EX/MEM pipeline register. It takes the registered `_s4` stage signals, resolves branches, runs a request/acknowledge handshake with a variable-latency data memory, and stalls the upstream pipeline while an access is outstanding. It also drives the MEM/WB register outputs (`_s5`).

## Interface
Parameters:
- `DATA_W`, 64: data and address width.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before abort. Used only when `MEM_TIMEOUT_EN` is defined.

Ports (clock and reset first):
- `clock` in 1: single clock, all state on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `RegWrite_s4`, `MemtoReg_s4`, `Branch_s4`, `MemRead_s4`, `MemWrite_s4` in 1 each: EX/MEM control signals.
- `BranchAdder_s4` in DATA_W: branch target.
- `Zero_s4` in 1: ALU zero flag.
- `ALUResult_s4` in DATA_W: ALU result, also the memory byte address.
- `RD2_s4` in DATA_W: store data.
- `WR_s4` in 5: destination register.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out DATA_W, `mem_wdata` out DATA_W: memory request.
- `mem_ack` in 1, `mem_rdata` in DATA_W: memory response.
- `stall` out 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `PCSrc` out 1, `BranchTarget` out DATA_W: branch redirect.
- `RegWrite_s5`, `MemtoReg_s5` out 1, `ReadData_s5` out DATA_W, `ALUResult_s5` out DATA_W, `WR_s5` out 5: MEM/WB outputs.
- `mem_err` out 1: sticky timeout flag.

## Operation
FSM states: IDLE, WAIT, DONE.

IDLE:
- A memory operation is present when `MemRead_s4 | MemWrite_s4`.
- With a memory operation: `stall`=1 combinationally. On the next edge, latch `mem_addr`=`ALUResult_s4`, `mem_wdata`=`RD2_s4` and `mem_we`=`MemWrite_s4`, set `mem_req`=1, and go to WAIT.
- If both `MemRead_s4` and `MemWrite_s4` are set, the write wins: `mem_we`=1 and `ReadData_s5`=0.
- Without a memory operation: `stall`=0 and the `_s5` outputs load from `_s4` on the next edge. `ReadData_s5` loads 0.

WAIT:
- `stall`=1, and `mem_req` is held with address, data and we stable.
- When `mem_ack`=1 is sampled: capture `mem_rdata` (reads only), drop `mem_req` on that edge, go to DONE.

DONE:
- `stall`=0.
- On the next edge, the `_s5` outputs load from `_s4` plus the captured read data, and the state goes to IDLE.
- EX/MEM advances on the same edge, so the completed operation is never restarted.

Bubbles: on every edge where `stall`=1, force `RegWrite_s5`=0 and `MemtoReg_s5`=0. The other `_s5` outputs hold.

Branch:
- `PCSrc` = `Branch_s4 & Zero_s4 & (state==IDLE)`, combinational.
- `BranchTarget` = `BranchAdder_s4`.

Other rules:
- `mem_ack` outside WAIT is ignored.
- `mem_addr` is `ALUResult_s4` verbatim. There is no alignment check.

## Timing
- Reset (asynchronous):
  - state goes to IDLE
  - `mem_req`, `mem_we`, `mem_err` and all `_s5` outputs go to 0
  - `mem_addr` and `mem_wdata` go to 0
- Reset mid-WAIT: `mem_req` drops immediately and the access is abandoned.
- Non-memory instruction: `_s5` valid one edge after the instruction appears in EX/MEM. No stall.
- Memory access acknowledged in the first WAIT cycle:
  - stall lasts 2 cycles (IDLE and WAIT)
  - DONE follows
  - `_s5` is valid 3 edges after the instruction appears
- Each additional WAIT cycle adds one stall cycle.
- `mem_req` rises one edge after the operation is seen, never combinationally.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without an ack: drop `mem_req`, set `mem_err` (sticky until reset), go to DONE with read data 0, and force `RegWrite_s5`=0 for that instruction.
- `MEM_TIMEOUT_EN` undefined: no counter, WAIT lasts until `mem_ack` indefinitely, and `mem_err` is tied to 0.

## Structure
- Package `mem_stage_pkg`:
  - state enum (IDLE, WAIT, DONE)
  - `DATA_W` default
  - `REG_ADDR_W`=5
- Sub-module `mem_wb_register`: the `_s5` register with a bubble input, instantiated once.
- The FSM, request latches and timeout counter stay in the top module.

## Test plan
1. ALU instruction: `RegWrite_s4`=1, `ALUResult_s4`=0x2A, `WR_s4`=3 -> next edge `RegWrite_s5`=1, `ALUResult_s5`=0x2A, `WR_s5`=3, and `stall` is never asserted.
2. LDUR at address 0x100 with `mem_ack` after 4 WAIT cycles and `mem_rdata`=0xDEAD -> `stall` high 5 cycles, `mem_req` high 4 cycles, then `ReadData_s5`=0xDEAD with `MemtoReg_s5`=1; `RegWrite_s5`=0 on every stalled edge.
3. STUR with `RD2_s4`=0x55 at address 0x8, immediate ack -> `mem_we`=1, `mem_wdata`=0x55, `mem_addr`=0x8 during WAIT; 2 stall cycles; `RegWrite_s5`=0.
4. CBZ with `Branch_s4`=1, `Zero_s4`=1, `BranchAdder_s4`=0x40 -> `PCSrc`=1 and `BranchTarget`=0x40 in the same cycle; with `Zero_s4`=0 -> `PCSrc`=0.
5. Assert `reset_n` low during WAIT -> `mem_req` and `stall` go to 0 asynchronously; after release, a new load completes normally.
6. With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no ack -> `mem_req` drops after 8 WAIT cycles, `mem_err`=1 and stays set, that instruction's `RegWrite_s5`=0, and the pipeline resumes.
